data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port memRead  input  1  load request from control unit.
REQ-006 SHALL have port memWrite  input  1  store request from control unit.
REQ-007 SHALL have port funct3  input  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port addr  input  32  byte address (ALU result).
REQ-009 SHALL have port wdata  input  32  store data (rs2).
REQ-010 SHALL have port rdata  output  32  extended load result, registered.
REQ-011 SHALL have port stall  output  1  hold PC/pipeline while access is in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port misaligned  output  1  one-cycle misaligned-access flag, coincident with done.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-015 In IDLE with memRead or memWrite high, SHALL capture addr, funct3, wdata, op, assert stall combinationally in that cycle, and go to WAIT (WAIT_CYCLES>0) or DONE (WAIT_CYCLES=0).
REQ-016 memWrite and memRead both high SHALL be treated as a write; read ignored.
REQ-017 WAIT SHALL load counter with WAIT_CYCLES on entry, hold stall=1, decrement each cycle, exit to DONE on the edge at which count reaches 1.
REQ-018 Memory write and rdata update SHALL occur on the edge entering DONE; total stall cycles = 1 + WAIT_CYCLES.
REQ-019 DONE SHALL assert done=1, stall=0 for exactly one cycle, ignore requests, then return to IDLE.
REQ-020 Loads: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW full word.
REQ-021 Stores: SB writes one byte lane, SH two lanes, SW four; untouched lanes SHALL keep their contents.
REQ-022 Reserved funct3 (3'b011, 3'b110, 3'b111) SHALL be treated as word access.
REQ-023 Word index SHALL be addr[log2(MEM_WORDS)+1:2]; higher bits ignored (wrap-around).
REQ-024 rdata SHALL hold last load result until next load completes; stores leave it unchanged.

Reset
REQ-025 rst SHALL force IDLE, counter 0, rdata 0, stall 0, done 0, misaligned 0.
REQ-026 rst mid-access (WAIT or DONE entry edge) SHALL abort: pending store not written, rdata not updated.
REQ-027 Memory array contents SHALL NOT be reset.

Configuration
REQ-028 Macro MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 SHALL suppress the access (no write, rdata unchanged) and pulse misaligned with done.
REQ-029 MISALIGN_TRAP_EN undefined: offending low address bits SHALL be forced to zero, access proceeds, misaligned tied 0.

Structure
REQ-030 funct3 load/store encodings and FSM state encodings SHALL live in the shared defines package next to the opcode constants.
REQ-031 Byte-lane storage SHALL be sub-module data_mem_array (clk, word index, 4-bit byte-enable, write data, read data); FSM, extension and alignment logic stay in data_mem_responder.

Verification
REQ-032 WAIT_CYCLES=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> each request stall=1 for 2 cycles, done pulse, rdata=0xDEADBEEF.
REQ-033 After REQ-032: LB 0x13 -> rdata=0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-034 SB 0x11 data 0x00000055 over 0xDEADBEEF, LW 0x10 -> 0xDEAD55EF.
REQ-035 rst pulsed in WAIT of SW 0x20 data 0x12345678 -> stall/done 0 next cycle; later LW 0x20 returns prior contents.
REQ-036 MISALIGN_TRAP_EN on: LW 0x12 -> misaligned=1 with done, rdata unchanged; off: LW 0x12 returns word at 0x10, misaligned=0.
REQ-037 MEM_WORDS=64: SW 0x100 data 0xA5A5A5A5, LW 0x000 -> 0xA5A5A5A5 (wrap-around); memRead+memWrite together -> write performed, rdata unchanged.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared defines for the data memory responder: opcodes, funct3 codes, FSM states.
// Build option: MISALIGN_TRAP_EN (see data_mem_responder.sv).
package data_mem_responder_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Reserved encodings (011, 110, 111) fall through to word access.
  function automatic size_t size_of(input logic [2:0] f3);
    size_t s;
    s = SZ_W;
    unique case (1'b1)
      (f3[1:0] == F3_LB[1:0]): s = SZ_B;
      (f3[1:0] == F3_LH[1:0]): s = SZ_H;
      default:                 s = SZ_W;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-lane data storage: write on clock edge per byte enable, combinational read.
// Contents are deliberately not reset.
module data_mem_array #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data memory responder with load extension and store lane steering.
// Define MISALIGN_TRAP_EN to suppress misaligned accesses and flag them.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS   = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam bit NOWAIT = (WAIT_CYCLES == 0);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        wr_q;

  logic        req;
  logic [31:0] a;
  logic [31:0] wd;
  logic [2:0]  f3;
  logic        wr;
  size_t       sz;
  logic [1:0]  off;
  logic        trap;
  logic        fin;
  logic [3:0]  be;
  logic [31:0] sdata;
  logic [31:0] rd_word;
  logic [31:0] ld;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        unused_hi;

  assign req = memRead | memWrite;

  // In IDLE the live request is used so a zero-wait access completes at once.
  always_comb begin
    a  = addr_q;
    wd = wdata_q;
    f3 = f3_q;
    wr = wr_q;
    if (state == IDLE) begin
      a  = addr;
      wd = wdata;
      f3 = funct3;
      wr = memWrite;
    end
  end

  assign sz = size_of(f3);
  assign unused_hi = ^a[31:AW+2];

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    trap = 1'b0;
    off  = a[1:0];
    unique case (1'b1)
      (sz == SZ_H): trap = a[0];
      (sz == SZ_W): trap = |a[1:0];
      default:      trap = 1'b0;
    endcase
  end
`else
  always_comb begin
    trap = 1'b0;
    off  = a[1:0];
    unique case (1'b1)
      (sz == SZ_H): off = {a[1], 1'b0};
      (sz == SZ_W): off = 2'b00;
      default:      off = a[1:0];
    endcase
  end
`endif

  assign fin = (state == IDLE && req && NOWAIT)
            || (state == WAIT && cnt == 4'd1);

  always_comb begin
    be    = 4'b0000;
    sdata = wd;
    unique case (1'b1)
      (sz == SZ_B): begin
        be    = 4'b0001 << off;
        sdata = {4{wd[7:0]}};
      end
      (sz == SZ_H): begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        sdata = {2{wd[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (!(fin && wr && !trap && !rst)) be = 4'b0000;
  end

  data_mem_array #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .idx   (a[AW+1:2]),
    .be    (be),
    .wdata (sdata),
    .rdata (rd_word)
  );

  always_comb begin
    lb = rd_word[{off, 3'b000} +: 8];
    lh = off[1] ? rd_word[31:16] : rd_word[15:0];
    ld = rd_word;
    unique case (1'b1)
      (sz == SZ_B): ld = {{24{lb[7] & ~f3[2]}}, lb};
      (sz == SZ_H): ld = {{16{lh[15] & ~f3[2]}}, lh};
      default:      ld = rd_word;
    endcase
  end

  assign stall = !rst && ((state == IDLE && req) || state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      wr_q       <= 1'b0;
      rdata      <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= funct3;
            wr_q    <= memWrite;
            if (NOWAIT) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fin) begin
        done       <= 1'b1;
        misaligned <= trap;
        if (!wr && !trap) rdata <= ld;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table bench for data_mem_responder (MEM_WORDS=64, WAIT_CYCLES=1).
module tb_data_mem_responder;

  localparam int WC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        misaligned;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .MEM_WORDS   (64),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .done       (done),
    .misaligned (misaligned)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  vec_t v[22];

`ifdef MISALIGN_TRAP_EN
  localparam logic MIS12 = 1'b1;
`else
  localparam logic MIS12 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic access(input int id, input logic w, input logic r,
                        input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp,
                        input logic mis);
    int   stalls;
    logic got;
    stalls = 0;
    got = 1'b0;
    @(negedge clk);
    memWrite = w;
    memRead  = r;
    funct3   = f;
    addr     = a;
    wdata    = d;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (stall) stalls++;
      if (done) begin
        got = 1'b1;
        chk($sformatf("v%0d_stall_at_done", id), {31'b0, stall}, 32'd0);
        chk($sformatf("v%0d_rdata", id), rdata, exp);
        chk($sformatf("v%0d_misaligned", id), {31'b0, misaligned},
            {31'b0, mis});
      end
      @(negedge clk);
      if (i == 0) begin
        memWrite = 1'b0;
        memRead  = 1'b0;
      end
    end
    chk($sformatf("v%0d_done_seen", id), {31'b0, got}, 32'd1);
    chk($sformatf("v%0d_stall_cycles", id), stalls, 1 + WC);
    #1;
    chk($sformatf("v%0d_done_one_cycle", id), {31'b0, done}, 32'd0);
  endtask

  initial begin
    v[0]  = '{1, 0, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 0};
    v[1]  = '{0, 1, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0};
    v[2]  = '{0, 1, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0};
    v[3]  = '{0, 1, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0};
    v[4]  = '{0, 1, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 0};
    v[5]  = '{0, 1, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 0};
    v[6]  = '{1, 0, 3'b000, 32'h11,  32'h00000055, 32'h0000BEEF, 0};
    v[7]  = '{0, 1, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0};
    v[8]  = '{0, 1, 3'b010, 32'h12,  32'h0,        32'hDEAD55EF, MIS12};
    v[9]  = '{1, 0, 3'b010, 32'h14,  32'h11223344, 32'hDEAD55EF, 0};
    v[10] = '{1, 0, 3'b001, 32'h16,  32'h0000CAFE, 32'hDEAD55EF, 0};
    v[11] = '{0, 1, 3'b010, 32'h14,  32'h0,        32'hCAFE3344, 0};
    v[12] = '{0, 1, 3'b101, 32'h16,  32'h0,        32'h0000CAFE, 0};
    v[13] = '{1, 0, 3'b010, 32'h100, 32'hA5A5A5A5, 32'h0000CAFE, 0};
    v[14] = '{0, 1, 3'b010, 32'h000, 32'h0,        32'hA5A5A5A5, 0};
    v[15] = '{1, 1, 3'b010, 32'h04,  32'h0BADF00D, 32'hA5A5A5A5, 0};
    v[16] = '{0, 1, 3'b010, 32'h04,  32'h0,        32'h0BADF00D, 0};
    v[17] = '{0, 1, 3'b000, 32'h04,  32'h0,        32'h0000000D, 0};
    v[18] = '{0, 1, 3'b011, 32'h04,  32'h0,        32'h0BADF00D, 0};
    v[19] = '{0, 1, 3'b001, 32'h06,  32'h0,        32'h00000BAD, 0};
    v[20] = '{0, 1, 3'b111, 32'h04,  32'h0,        32'h0BADF00D, 0};
    v[21] = '{1, 0, 3'b010, 32'h20,  32'h0F0F0F0F, 32'h0BADF00D, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_misaligned", {31'b0, misaligned}, 32'd0);

    for (int i = 0; i < 22; i++) begin
      access(i, v[i].w, v[i].r, v[i].f3, v[i].a, v[i].d, v[i].exp, v[i].mis);
    end

    // Reset in the middle of a store must abort it.
    @(negedge clk);
    memWrite = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h20;
    wdata    = 32'h12345678;
    #1;
    chk("abort_stall_req", {31'b0, stall}, 32'd1);
    @(negedge clk);
    memWrite = 1'b0;
    #1;
    chk("abort_stall_wait", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    rst = 1'b0;
    access(100, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 32'h0F0F0F0F, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
